load_store_unit: RTL
====================

# load_store_unit

Data-memory access sequencer sitting directly downstream of the control unit. It consumes `memory_read`/`memory_write` plus `funct3`, the ALU-computed address and the rs2 store data. It drives a request/acknowledge handshake to the data memory and returns `read_done`/`write_done` to the control unit, which gate its PC stall and output enables. It performs byte-lane steering on stores and alignment plus sign/zero extension on loads, and aborts a stuck access after a bounded wait.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles in ACCESS without `mem_ack` before abort; range 1–65535.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `memory_read`  in  1  load requested by control unit.
- `memory_write`  in  1  store requested by control unit.
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `address`  in  32  byte address from the ALU.
- `store_data`  in  32  rs2 value, right-aligned.
- `read_done`  out  1  load complete; `load_data` valid.
- `write_done`  out  1  low only while a store is outstanding.
- `load_data`  out  32  extended load result, to the register-file write mux.
- `bus_error`  out  1  one-cycle pulse on timeout abort.
- `misaligned`  out  1  one-cycle pulse on rejected misaligned access (macro-dependent).
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address, with `[1:0]` = 00.
- `mem_wdata`  out  32  lane-steered store data.
- `mem_wstrb`  out  4  byte write strobes; 0000 on reads.
- `mem_ack`  in  1  access complete; `mem_rdata` valid in the same cycle for reads.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On `memory_write` or `memory_read`, latch `address`, `funct3`, `store_data` and the direction, then go to ACCESS.
  - If both requests are high, the store wins and the read is ignored.
- ACCESS:
  - `mem_req`=1. `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are driven from the latched values and held stable.
  - On `mem_ack`, capture the extended read data and go to DONE.
- DONE: one cycle, then IDLE unconditionally. A `memory_read`/`memory_write` still high in DONE belongs to the finished instruction and is ignored.
- Store steering, by `a = addr[1:0]`:
  - SB: strobe `1<<a`; data byte replicated to all four lanes.
  - SH: strobe `0011<<a` (lanes 0 or 2); data halfword replicated to both halves.
  - SW: strobe 1111.
- Load extraction:
  - B/BU: byte at lane `a`.
  - H/HU: halfword at `a[1]`.
  - W: full word.
  - Signed sizes sign-extend from bit 7 or bit 15; BU/HU zero-extend.
  - Reserved `funct3` values are treated as W.
- Timeout:
  - A 16-bit counter clears on entry to ACCESS and increments each cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`: drop `mem_req`, pulse `bus_error`, set `load_data`=0, go to DONE.

## Timing
- Reset values: `mem_req` 0, `mem_we` 0, `mem_wstrb` 0, `mem_addr` 0, `mem_wdata` 0, `read_done` 0, `write_done` 1, `load_data` 0, `bus_error` 0, `misaligned` 0. State is IDLE.
- Reset asserted mid-access returns to IDLE and drops `mem_req` immediately (asynchronously). A late `mem_ack` after reset is ignored.
- Request sampled in IDLE at cycle N:
  - `mem_req` high from N+1.
  - Earliest ack at N+1, giving DONE at N+2.
- `read_done`=1 only in DONE of a load; `load_data` is registered and held until the next load's DONE.
- `write_done`=0 from N+1 through the ack cycle, and 1 in DONE and IDLE.
- An ack arriving in the same cycle the timeout is reached counts as success; no error is raised.
- `bus_error` and `misaligned` pulse in the DONE cycle.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠00, issues no memory request.
  - Path is IDLE → DONE directly (IDLE→DONE at N+1).
  - `misaligned` pulses in DONE; a load returns 0; a store writes nothing.
- Undefined:
  - Ignored address bits are forced: H uses only `addr[1]`; W uses `addr[1:0]`=00.
  - All accesses go to memory.
  - `misaligned` is tied 0.

## Structure
- Header `modules/headers/load_store.vh`: size/sign `funct3` constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and state encodings (LSU_IDLE, LSU_ACCESS, LSU_DONE).
- One sub-module, `load_data_aligner`: combinational extraction and sign/zero extension from `mem_rdata`, `addr[1:0]` and `funct3`.

## Test plan
- LW at 0x100, ack after 3 wait cycles, `mem_rdata`=0xDEADBEEF → `mem_req` high for 4 cycles, `read_done` pulses once, `load_data`=0xDEADBEEF.
- LB at 0x103, rdata 0x80112233 → `load_data`=0xFFFFFF80; same access as LBU → 0x00000080.
- SH at 0x202, `store_data` 0x0000ABCD → `mem_addr` 0x200, `mem_wstrb` 1100, `mem_wdata` 0xABCDABCD, `write_done` low until ack.
- No ack with `TIMEOUT_CYCLES`=4 → `mem_req` drops after 4 cycles, `bus_error` pulses, `load_data`=0, state IDLE.
- LW at 0x101 → with the macro: no `mem_req`, `misaligned` pulse, `read_done` at N+1. Without the macro: `mem_addr`=0x100, normal load.
- `reset_n` low during ACCESS → `mem_req` drops immediately, `write_done`=1, and a subsequent `mem_ack` has no effect.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared constants for the load/store unit: funct3 size/sign
//               encodings, FSM state encodings and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    // funct3 access size / sign encodings
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] LSU_IDLE   = 2'd0;
    localparam logic [1:0] LSU_ACCESS = 2'd1;
    localparam logic [1:0] LSU_DONE   = 2'd2;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == LSU_B) || (f3 == LSU_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == LSU_H) || (f3 == LSU_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_aligner.sv
`default_nettype none
// ============================================================================
// Module      : load_data_aligner
// Description : Combinational load-data extraction. Selects the byte or
//               halfword addressed by i_addr_lo out of the read word and
//               sign- or zero-extends it according to i_funct3. Reserved
//               funct3 values return the full word.
// Ports       : i_rdata   [31:0] read word from memory
//               i_addr_lo [1:0]  low address bits of the access
//               i_funct3  [2:0]  access size / sign
//               o_data    [31:0] extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module load_data_aligner
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        // Halfwords only look at bit 1; bit 0 is ignored for alignment.
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            LSU_B:   o_data = {{24{w_byte[7]}}, w_byte};
            LSU_BU:  o_data = {24'h000000, w_byte};
            LSU_H:   o_data = {{16{w_half[15]}}, w_half};
            LSU_HU:  o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory access sequencer. Latches a load/store request
//               from the control unit, runs a req/ack handshake to data
//               memory with byte-lane steering on stores and aligned,
//               extended results on loads, and aborts an access that gets
//               no ack within TIMEOUT_CYCLES cycles.
// Macro       : LSU_MISALIGN_CHECK_EN - when defined, misaligned halfword /
//               word accesses are rejected without a memory request and
//               flagged on 'misaligned'. Undefined: ignored address bits are
//               forced and the access proceeds.
// Ports       : clk, reset_n (async, active low)
//               memory_read/memory_write/funct3/address/store_data - request
//               read_done/write_done/load_data - completion to control unit
//               bus_error/misaligned - one-cycle error pulses
//               mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb - memory request
//               mem_ack/mem_rdata - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        read_done,
    output logic        write_done,
    output logic [31:0] load_data,
    output logic        bus_error,
    output logic        misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Last counter value at which an un-acked ACCESS cycle still ends in abort
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_load_data;
    logic        r_bus_error;
    logic        r_misaligned;

    logic        w_req_valid;
    logic        w_misalign;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_aligned;

    assign w_req_valid = memory_read | memory_write;
    assign w_timeout   = (r_cnt == c_timeout_last);

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = (is_half(funct3) && address[0]) ||
                        (!is_byte(funct3) && !is_half(funct3) && (address[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane steering; data is replicated so the strobe alone selects lanes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
        if (is_byte(funct3)) begin
            w_wstrb = 4'b0001 << address[1:0];
            w_wdata = {4{store_data[7:0]}};
        end else if (is_half(funct3)) begin
            w_wstrb = address[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{store_data[15:0]}};
        end
        if (!memory_write) begin
            w_wstrb = 4'b0000;
        end
    end

    load_data_aligner u_aligner (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_aligned)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_req_valid) begin
                    w_state_nxt = w_misalign ? LSU_DONE : LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = LSU_DONE;
                end
            end
            LSU_DONE:  w_state_nxt = LSU_IDLE;
            default:   w_state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= LSU_IDLE;
            r_cnt        <= 16'h0000;
            r_we         <= 1'b0;
            r_funct3     <= LSU_W;
            r_addr_lo    <= 2'b00;
            r_addr       <= 32'h0000_0000;
            r_wdata      <= 32'h0000_0000;
            r_wstrb      <= 4'b0000;
            r_load_data  <= 32'h0000_0000;
            r_bus_error  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bus_error  <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_req_valid) begin
                        r_we      <= memory_write;
                        r_funct3  <= funct3;
                        r_addr_lo <= address[1:0];
                        r_addr    <= {address[31:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_wstrb;
                        r_cnt     <= 16'h0000;
                        if (w_misalign) begin
                            r_misaligned <= 1'b1;
                            if (!memory_write) begin
                                r_load_data <= 32'h0000_0000;
                            end
                        end
                    end
                end
                LSU_ACCESS: begin
                    // An ack on the final allowed cycle wins over the abort.
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_load_data <= w_aligned;
                        end
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        if (!r_we) begin
                            r_load_data <= 32'h0000_0000;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Derived from the async-reset state so reset drops the request at once.
    assign mem_req    = (r_state == LSU_ACCESS);
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign read_done  = (r_state == LSU_DONE) && !r_we;
    assign write_done = !((r_state == LSU_ACCESS) && r_we);
    assign load_data  = r_load_data;
    assign bus_error  = r_bus_error;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire
